// File: rtl/boot_copy_ctrl.sv
// Boot sequencer: optionally copies the boot image into SRAM, then holds
// the CPU in reset for a few cycles before releasing it.
module boot_copy_ctrl #(
    parameter int COPY_WORDS = 256,
    parameter int ADDR_W     = 14,
    parameter int HOLD_CYC   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              boot_sel,
    input  logic              copy_en,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic              cpu_hold,
    output logic              remap,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(COPY_WORDS - 1);

    typedef enum logic [2:0] {
        SAMPLE,
        READ,
        WRITE,
        RELEASE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [31:0]         data_q, data_d;
    logic                sel_q, sel_d;
    logic                err_q, err_d;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= SAMPLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // Wait and hold counters default to zero so every state entry starts clean.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = '0;
        hold_d  = '0;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = err_q;
        unique case (state_q)
            SAMPLE: begin
                sel_d   = boot_sel;
                state_d = (!boot_sel && copy_en) ? READ : RELEASE;
            end
            READ: begin
                if (rd_valid) begin
                    data_d  = rd_data;
                    state_d = WRITE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    sel_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = (cnt_q == CNT_LAST) ? RELEASE : READ;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    sel_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RELEASE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = DONE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = SAMPLE;
            end
        endcase
    end

    assign rd_req    = (state_q == READ);
    assign wr_en     = (state_q == WRITE);
    assign rd_addr   = cnt_q;
    assign wr_addr   = cnt_q;
    assign wr_data   = data_q;
    assign cpu_hold  = (state_q != DONE);
    assign boot_done = (state_q == DONE);
    assign boot_err  = err_q;
    // Vectors come from boot space until the sequence reaches release.
    assign remap     = (state_q == RELEASE || state_q == DONE) ? sel_q : 1'b0;

endmodule
